mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the number of idle response cycles tolerated before an error completion (range 1..255).
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 if_req  input  1  instruction-fetch request, held until if_gnt.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_gnt / if_rvalid  output  1 each  fetch accept pulse / fetch data-valid pulse.
REQ-007 if_rdata  output  32  fetch data.
REQ-008 ls_req, ls_we  input  1 each  load/store request, held until ls_gnt / write-enable (1 = store).
REQ-009 ls_addr, ls_wdata  input  32 each  data address / store data.
REQ-010 ls_be  input  4  store byte enables.
REQ-011 ls_gnt / ls_rvalid  output  1 each  load/store accept pulse / completion pulse (loads and stores).
REQ-012 ls_rdata  output  32  load data.
REQ-013 mem_req, mem_we  output  1 each  memory request / write-enable.
REQ-014 mem_addr, mem_wdata  output  32 each; mem_be  output  4.
REQ-015 mem_gnt, mem_rvalid  input  1 each  memory accept / completion (returned for reads and writes).
REQ-016 mem_rdata  input  32  memory read data.
REQ-017 bus_err  output  1  one-cycle pulse on timeout completion.

Function
REQ-018 FSM states IDLE, REQ, RESP; one outstanding transaction max.
REQ-019 IDLE: any request -> xx_gnt=1 combinationally to the winner only, winner's addr/wdata/be/we captured into internal registers at that edge, owner recorded, next state REQ.
REQ-020 Arbitration: single requester wins; both requesting -> port not recorded in last_owner wins (round-robin); last_owner updates on every grant.
REQ-021 Fetch grants SHALL drive captured we=0 and be=4'b0000.
REQ-022 REQ: mem_req=1, mem_* driven only from captured registers; mem_gnt=1 -> RESP; otherwise hold all mem_* stable.
REQ-023 RESP: mem_req=0; mem_rvalid=1 -> owner's xx_rvalid=1 and xx_rdata=mem_rdata same cycle (combinational), next state IDLE.
REQ-024 Non-owner rvalid SHALL stay 0; both rdata outputs SHALL be 0 whenever their rvalid is 0.
REQ-025 Timeout counter (8 bit) cleared on RESP entry, increments each RESP cycle without mem_rvalid.
REQ-026 RESP, counter == TIMEOUT, mem_rvalid=0 -> owner rvalid=1, rdata=0, bus_err=1 for that cycle, next state IDLE.
REQ-027 mem_rvalid in IDLE or REQ SHALL be ignored (no rvalid, no state change); late response after timeout is therefore dropped.
REQ-028 No grant in REQ or RESP; pending requests wait for IDLE; minimum turnaround: grant, REQ, RESP+rvalid = 3 cycles, next grant the cycle after rvalid.
REQ-029 Requests deasserted before grant SHALL be dropped without side effect.

Reset
REQ-030 reset_n low SHALL asynchronously force IDLE, counter 0, last_owner = fetch, captured registers 0, all outputs 0.
REQ-031 Reset mid-transaction SHALL abandon it; no rvalid/bus_err for it after release; first tie after reset SHALL go to load/store.

Verification
REQ-032 Fetch only, if_addr=0x100, mem_gnt immediate, mem_rvalid next cycle rdata=0x00500093 -> if_gnt cycle 0, mem_req/mem_addr=0x100 cycle 1, if_rvalid/if_rdata=0x00500093 cycle 2.
REQ-033 if_req and ls_req together after reset -> ls_gnt first; after completion, held if_req granted next; repeated ties alternate LS, IF, LS.
REQ-034 Store ls_addr=0x2000, ls_wdata=0xDEADBEEF, ls_be=4'b0011, mem_gnt delayed 3 cycles -> mem_* stable all 3 cycles, ls_rvalid on mem_rvalid, ls_rdata=0.
REQ-035 TIMEOUT=4, load granted, mem_rvalid never -> ls_rvalid=1, ls_rdata=0, bus_err=1 on 5th RESP cycle; later stray mem_rvalid produces nothing.
REQ-036 reset_n pulsed low during RESP -> all outputs 0 immediately; subsequent mem_rvalid ignored; next if_req granted normally.
REQ-037 ls_req dropped before grant while FSM busy -> no ls_gnt, no memory access issued for it.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store,
// round-robin on ties, one outstanding transaction, response timeout with bus_err.
module mem_port_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_be,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_nx;
  logic last_ls, cap_we, win_ls, grant, expired, done;
  logic [31:0] cap_addr, cap_wdata, rdata;
  logic [3:0] cap_be;
  logic [7:0] cnt;
  // last_ls doubles as the owner of the transaction in flight
  assign win_ls  = ls_req && (!if_req || !last_ls);
  assign grant   = reset_n && (state == IDLE) && (if_req || ls_req);
  assign expired = (state == RESP) && !mem_rvalid && (cnt == 8'(TIMEOUT));
  assign done    = (state == RESP) && (mem_rvalid || expired);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = grant ? REQ : (state == REQ && mem_gnt) ? RESP : done ? IDLE : state;
  always_comb begin
    if_gnt    = grant && !win_ls;
    ls_gnt    = grant && win_ls;
    mem_req   = state == REQ;
    mem_we    = cap_we;
    mem_addr  = cap_addr;
    mem_wdata = cap_wdata;
    mem_be    = cap_be;
    rdata     = (mem_rvalid && !cap_we) ? mem_rdata : '0;
    if_rvalid = done && !last_ls;
    ls_rvalid = done && last_ls;
    if_rdata  = if_rvalid ? rdata : '0;
    ls_rdata  = ls_rvalid ? rdata : '0;
    bus_err   = expired;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      last_ls   <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
      cnt       <= '0;
    end else begin
      if (grant) begin
        last_ls   <= win_ls;
        cap_we    <= win_ls && ls_we;
        cap_addr  <= win_ls ? ls_addr : if_addr;
        cap_wdata <= win_ls ? ls_wdata : '0;
        cap_be    <= win_ls ? ls_be : '0;
      end
      cnt <= (state == REQ) ? '0 : (state == RESP && !mem_rvalid) ? cnt + 8'd1 : cnt;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and a randomized run
// checked against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
  localparam int TO = 4;
  typedef logic [138:0] vec_t;
  typedef struct {
    logic [3:0]  in_f;
    logic [31:0] rd;
    logic [2:0]  g_f;
    logic [31:0] ema;
    logic [1:0]  v_f;
  } row_t;

  logic clk, reset_n;
  logic if_req, ls_req, ls_we, mem_gnt, mem_rvalid;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [3:0] ls_be;
  logic if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we, bus_err;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  int total = 0, bad = 0;
  row_t tbl[$];

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t pk(input logic ig, lg, ir, lr, er, mr, input logic [31:0] ird, lrd, ma, mwd,
                              input logic [3:0] mbe, input logic mwe);
    return {ig, lg, ir, lr, er, mr, ird, lrd, mr ? {ma, mwd, mbe, mwe} : 69'd0};
  endfunction

  function automatic vec_t obs();
    return pk(if_gnt, ls_gnt, if_rvalid, ls_rvalid, bus_err, mem_req, if_rdata, ls_rdata,
              mem_addr, mem_wdata, mem_be, mem_we);
  endfunction

  task automatic ck_raw(input string nm, input vec_t a, input vec_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask

  task automatic ck(input string nm, input vec_t e);
    #2;
    ck_raw(nm, obs(), e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    if_req = 0; ls_req = 0; ls_we = 0; mem_gnt = 0; mem_rvalid = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0; ls_be = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    idle_in();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  task automatic t(input logic [3:0] in_f, input logic [31:0] rd, input logic [2:0] g_f,
                   input logic [31:0] ema, input logic [1:0] v_f);
    tbl.push_back('{in_f, rd, g_f, ema, v_f});
  endtask

  bit busy, resp, last_ls, t_ls, t_we, ih, lh, wl, dn, eig, elg, eiv, elv, eer, emr, lwe;
  int k;
  logic [31:0] t_addr, t_wd, ia, la, lwd, d;
  logic [3:0] t_be, lbe;

  initial begin
    // in_f = {if_req, ls_req, mem_gnt, mem_rvalid}; g_f = {if_gnt, ls_gnt, mem_req}; v_f = {if_rvalid, ls_rvalid}
    t(4'b1000, 32'h0,        3'b100, 32'h0,    2'b00);
    t(4'b0010, 32'h0,        3'b001, 32'h100,  2'b00);
    t(4'b0001, 32'h00500093, 3'b000, 32'h0,    2'b10);
    t(4'b1100, 32'h0,        3'b010, 32'h0,    2'b00);
    t(4'b1010, 32'h0,        3'b001, 32'h2000, 2'b00);
    t(4'b1001, 32'h11111111, 3'b000, 32'h0,    2'b01);
    t(4'b1100, 32'h0,        3'b100, 32'h0,    2'b00);
    t(4'b0110, 32'h0,        3'b001, 32'h100,  2'b00);
    t(4'b0101, 32'h22222222, 3'b000, 32'h0,    2'b10);
    t(4'b1100, 32'h0,        3'b010, 32'h0,    2'b00);
    t(4'b1010, 32'h0,        3'b001, 32'h2000, 2'b00);
    t(4'b1001, 32'h33333333, 3'b000, 32'h0,    2'b01);

    // reset: outputs quiet even with both requests pending
    reset_n = 0;
    idle_in();
    #1 if_req = 1; ls_req = 1;
    ck("reset_quiet", '0);
    do_reset();
    ck("reset_idle", '0);

    // table: fetch timing, then tie alternation LS, IF, LS
    foreach (tbl[i]) begin
      {if_req, ls_req, mem_gnt, mem_rvalid} = tbl[i].in_f;
      mem_rdata = tbl[i].rd; if_addr = 32'h100; ls_addr = 32'h2000;
      ck($sformatf("tbl%0d", i), pk(tbl[i].g_f[2], tbl[i].g_f[1], tbl[i].v_f[1], tbl[i].v_f[0], 1'b0,
         tbl[i].g_f[0], tbl[i].v_f[1] ? tbl[i].rd : 32'h0, tbl[i].v_f[0] ? tbl[i].rd : 32'h0,
         tbl[i].ema, 32'h0, 4'h0, 1'b0));
      cyc();
    end

    // store with mem_gnt held off three cycles
    do_reset();
    ls_req = 1; ls_we = 1; ls_addr = 32'h2000; ls_wdata = 32'hDEADBEEF; ls_be = 4'b0011;
    ck("st_gnt", pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc();
    ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0; ls_be = 0;
    for (int i = 0; i < 4; i++) begin
      mem_gnt = (i == 3);
      ck($sformatf("st_hold%0d", i), pk(0, 0, 0, 0, 0, 1, 0, 0, 32'h2000, 32'hDEADBEEF, 4'b0011, 1));
      cyc();
    end
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    ck("st_done", pk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc();

    // load that never completes: error on 5th response cycle, stray response dropped
    do_reset();
    ls_req = 1; ls_addr = 32'h3000;
    ck("to_gnt", pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc();
    ls_req = 0; mem_gnt = 1;
    ck("to_req", pk(0, 0, 0, 0, 0, 1, 0, 0, 32'h3000, 0, 0, 0));
    cyc();
    mem_gnt = 0;
    for (int i = 0; i < TO; i++) begin
      ck($sformatf("to_wait%0d", i), '0);
      cyc();
    end
    ck("to_err", pk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    cyc();
    mem_rvalid = 1; mem_rdata = 32'h12345678;
    for (int i = 0; i < 2; i++) begin
      ck($sformatf("to_stray%0d", i), '0);
      cyc();
    end
    mem_rvalid = 0;

    // reset pulse during the response phase
    do_reset();
    ls_req = 1; ls_addr = 32'h4000;
    ck("rp_gnt", pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc();
    ls_req = 0; mem_gnt = 1;
    cyc();
    mem_gnt = 0;
    reset_n = 0;
    ck("rp_out", '0);
    ck_raw("rp_mem", vec_t'({mem_addr, mem_wdata, mem_be, mem_we}), '0);
    cyc();
    reset_n = 1; mem_rvalid = 1; mem_rdata = 32'hAAAA5555;
    ck("rp_stray", '0);
    cyc();
    mem_rvalid = 0; if_req = 1; if_addr = 32'h500;
    ck("rp_next", pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc();
    if_req = 0;

    // load/store request withdrawn while the fetch is outstanding
    do_reset();
    if_req = 1; if_addr = 32'h600;
    ck("dr_gnt", pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc();
    if_req = 0; ls_req = 1; ls_addr = 32'h7000;
    ck("dr_busy", pk(0, 0, 0, 0, 0, 1, 0, 0, 32'h600, 0, 0, 0));
    cyc();
    mem_gnt = 1;
    ck("dr_req", pk(0, 0, 0, 0, 0, 1, 0, 0, 32'h600, 0, 0, 0));
    cyc();
    mem_gnt = 0; ls_req = 0; mem_rvalid = 1; mem_rdata = 32'h77;
    ck("dr_done", pk(0, 0, 1, 0, 0, 0, 32'h77, 0, 0, 0, 0, 0));
    cyc();
    mem_rvalid = 0;
    for (int i = 0; i < 3; i++) begin
      ck($sformatf("dr_quiet%0d", i), '0);
      cyc();
    end

    // randomized traffic against a transaction-level model
    do_reset();
    busy = 0; resp = 0; last_ls = 0; ih = 0; lh = 0; k = 0;
    t_ls = 0; t_we = 0; t_addr = 0; t_wd = 0; t_be = 0;
    ia = 0; la = 0; lwd = 0; lbe = 0; lwe = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!ih && $urandom_range(0, 2) == 0) begin ih = 1; ia = $urandom; end
      else if (ih && $urandom_range(0, 15) == 0) ih = 0;
      if (!lh && $urandom_range(0, 2) == 0) begin
        lh = 1; la = $urandom; lwd = $urandom; lbe = 4'($urandom); lwe = 1'($urandom);
      end else if (lh && $urandom_range(0, 15) == 0) lh = 0;
      if_req = ih; if_addr = ia; ls_req = lh; ls_addr = la; ls_wdata = lwd; ls_be = lbe; ls_we = lwe;
      mem_gnt = 1'($urandom); mem_rvalid = ($urandom_range(0, 3) == 0); mem_rdata = $urandom;
      eig = 0; elg = 0; eiv = 0; elv = 0; eer = 0; emr = 0; dn = 0; d = 0;
      if (!busy) begin
        if (ih && lh) wl = !last_ls;
        else wl = lh;
        eig = ih && !wl;
        elg = lh && wl;
      end else if (!resp) emr = 1;
      else begin
        eer = !mem_rvalid && k == TO;
        dn = mem_rvalid || eer;
        d = (mem_rvalid && !t_we) ? mem_rdata : 32'h0;
        eiv = dn && !t_ls;
        elv = dn && t_ls;
      end
      ck("rand", pk(eig, elg, eiv, elv, eer, emr, eiv ? d : 32'h0, elv ? d : 32'h0, t_addr, t_wd, t_be, t_we));
      if (eig || elg) begin
        busy = 1; resp = 0; t_ls = elg; last_ls = elg;
        t_addr = elg ? la : ia; t_wd = elg ? lwd : 32'h0; t_be = elg ? lbe : 4'h0; t_we = elg && lwe;
        if (elg) lh = 0;
        else ih = 0;
      end else if (busy && !resp) begin
        if (mem_gnt) begin resp = 1; k = 0; end
      end else if (busy) begin
        if (dn) busy = 0;
        else k++;
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
